// File: rtl/fir_pkg.sv
// Shared types and width helpers for the time-multiplexed FIR filter.
package fir_pkg;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  function automatic int width_m(input int width_x, input int width_b);
    return width_x + width_b;
  endfunction

  // Growth of clog2(N+1) bits keeps N+1 worst-case products from overflowing.
  function automatic int width_y(input int width_x, input int width_b, input int n);
    return width_m(width_x, width_b) + $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Signed multiply-accumulate unit; the product is sign-extended before accumulation.
module fir_mac #(
  parameter int WIDTH_A = 8,
  parameter int WIDTH_B = 8,
  parameter int WIDTH_Y = 19
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      en,
  input  logic signed [WIDTH_A-1:0] a,
  input  logic signed [WIDTH_B-1:0] b,
  output logic signed [WIDTH_Y-1:0] acc
);

  localparam int WIDTH_M = WIDTH_A + WIDTH_B;

  logic signed [WIDTH_M-1:0] prod;
  logic signed [WIDTH_Y-1:0] prod_ext;

  assign prod     = a * b;
  assign prod_ext = {{(WIDTH_Y-WIDTH_M){prod[WIDTH_M-1]}}, prod};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/fir_filter_tdm.sv
// Multi-channel FIR sharing one MAC. States: IDLE | accept sample / coef writes,
// MAC | N+1 accumulate cycles plus one result-register cycle, OUT | hold result until m_ready.
module fir_filter_tdm
  import fir_pkg::*;
#(
  parameter int N       = 7,
  parameter int CH      = 2,
  parameter int WIDTH_X = 8,
  parameter int WIDTH_B = 8,
  localparam int WIDTH_Y = width_y(WIDTH_X, WIDTH_B, N),
  localparam int WIDTH_K = $clog2(N + 1),
  localparam int WIDTH_C = $clog2(CH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      coef_we,
  input  logic [WIDTH_K-1:0]        coef_addr,
  input  logic signed [WIDTH_B-1:0] coef_data,
  output logic                      coef_busy,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic signed [WIDTH_X-1:0] s_data,
  input  logic [WIDTH_C-1:0]        s_ch,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic signed [WIDTH_Y-1:0] m_data,
  output logic [WIDTH_C-1:0]        m_ch
);

  state_t                    state;
  logic [WIDTH_K-1:0]        k;
  logic                      last;
  logic [WIDTH_C-1:0]        ch;
  logic signed [WIDTH_B-1:0] coef [N+1];
  logic signed [WIDTH_X-1:0] z [CH][N+1];
  logic signed [WIDTH_Y-1:0] acc;
  logic                      accept;
  logic                      mac_en;

  assign s_ready   = (state == IDLE) && !rst;
  assign coef_busy = (state != IDLE);
  assign accept    = s_valid && s_ready;
  assign mac_en    = (state == MAC) && !last;

  fir_mac #(
    .WIDTH_A (WIDTH_B),
    .WIDTH_B (WIDTH_X),
    .WIDTH_Y (WIDTH_Y)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (mac_en),
    .a   (coef[k]),
    .b   (z[ch][k]),
    .acc (acc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      k       <= '0;
      last    <= 1'b0;
      ch      <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_ch    <= '0;
      for (int j = 0; j <= N; j++) coef[j] <= '0;
      for (int c = 0; c < CH; c++)
        for (int j = 0; j <= N; j++) z[c][j] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (coef_we && (32'(coef_addr) <= N)) coef[coef_addr] <= coef_data;
          if (s_valid) begin
            // Out-of-range channels still produce a result but never touch a delay line.
            if (32'(s_ch) < CH) begin
              z[s_ch][0] <= s_data;
              for (int j = 1; j <= N; j++) z[s_ch][j] <= z[s_ch][j-1];
            end
            ch    <= WIDTH_C'(32'(s_ch) % CH);
            k     <= '0;
            last  <= 1'b0;
            state <= MAC;
          end
        end
        MAC: begin
          if (last) begin
            state   <= OUT;
            m_valid <= 1'b1;
            m_data  <= acc;
            m_ch    <= ch;
            last    <= 1'b0;
          end else if (k == WIDTH_K'(N)) begin
            last <= 1'b1;
          end else begin
            k <= k + WIDTH_K'(1);
          end
        end
        OUT: begin
          if (m_ready) begin
            state   <= IDLE;
            m_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
